pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipeline_hazard_ctrl_if.sv | 59 +++++
 rtl/pipeline_hazard_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle of every signal between the pipeline datapath and the hazard
// controller.
//   master : pipeline side. It drives the register indices, the load, write
//            and multi-cycle flags, redirect and clr_counters. It receives
//            the load, flush and bubble controls, the forwarding selects,
//            mc_busy and the event counters.
//   slave  : hazard controller side, with the directions reversed.
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int LAT_W  = 4,
   parameter int CNT_W  = 16
);
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic [REG_AW-1:0] ex_rs1;
   logic [REG_AW-1:0] ex_rs2;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_memread;
   logic              ex_mc_start;
   logic [LAT_W-1:0]  ex_mc_lat;
   logic [REG_AW-1:0] mem_rd;
   logic              mem_regwrite;
   logic [REG_AW-1:0] wb_rd;
   logic              wb_regwrite;
   logic              redirect;
   logic              clr_counters;
   logic              pc_write;
   logic              if_id_load;
   logic              if_id_flush;
   logic              id_ex_load;
   logic              id_ex_bubble;
   logic              ex_mem_bubble;
   logic [1:0]        forward_a;
   logic [1:0]        forward_b;
   logic              mc_busy;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
             ex_memread, ex_mc_start, ex_mc_lat, mem_rd, mem_regwrite, wb_rd,
             wb_regwrite, redirect, clr_counters,
      input  pc_write, if_id_load, if_id_flush, id_ex_load, id_ex_bubble,
             ex_mem_bubble, forward_a, forward_b, mc_busy, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
             ex_memread, ex_mc_start, ex_mc_lat, mem_rd, mem_regwrite, wb_rd,
             wb_regwrite, redirect, clr_counters,
      output pc_write, if_id_load, if_id_flush, id_ex_load, id_ex_bubble,
             ex_mem_bubble, forward_a, forward_b, mc_busy, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central hazard controller for the 5-stage RV32 pipeline. It handles the
// following cases:
//   - load-use stalls
//   - multi-cycle EX occupancy (RUN / MC_BUSY FSM)
//   - redirect flushes, squashing FLUSH_DEPTH younger stages
//   - EX operand forwarding
// It also keeps saturating stall and flush event counters.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   hz  : pipeline_hazard_ctrl_if.slave, carrying all pipeline-side signals
// The stall, flush and forwarding controls are combinational within the
// cycle. mc_busy and the counters are registered.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
   parameter int REG_AW      = 5,
   parameter int LAT_W       = 4,
   parameter int CNT_W       = 16,
   parameter int FLUSH_DEPTH = 3
) (
   input  logic clk,
   input  logic rst,
   pipeline_hazard_ctrl_if.slave hz
);

   typedef enum logic [0:0] {ST_RUN = 1'b0, ST_MC_BUSY = 1'b1} state_e;

   localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [LAT_W-1:0]  REM_ZERO = {LAT_W{1'b0}};

   // Forward source select: MEM (10) beats WB (01); x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] src,
      input logic [REG_AW-1:0] m_rd,
      input logic              m_wr,
      input logic [REG_AW-1:0] w_rd,
      input logic              w_wr
   );
      logic [1:0] sel;
      if (m_wr && (m_rd != REG_ZERO) && (m_rd == src)) begin
         sel = 2'b10;
      end else if (w_wr && (w_rd != REG_ZERO) && (w_rd == src)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   state_e           state_q, state_d;
   logic [LAT_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic       lu_s, mcs_s, hold_s;
   logic       pc_write_s, if_id_load_s, if_id_flush_s;
   logic       id_ex_load_s, id_ex_bubble_s, ex_mem_bubble_s;
   logic [1:0] forward_a_s, forward_b_s;

   // Hazard conditions derived from the current stage contents and FSM state.
   always_comb begin
      lu_s = hz.ex_memread && (hz.ex_rd != REG_ZERO) &&
             ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
              (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
      // Latencies 0 and 1 are plain single-cycle ops.
      mcs_s  = (state_q == ST_RUN) && hz.ex_mc_start &&
               (hz.ex_mc_lat >= LAT_W'(2)) && !hz.redirect;
      hold_s = mcs_s || (state_q == ST_MC_BUSY);
   end

   // FSM state register; reset abandons any multi-cycle op in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_RUN;
         rem_q   <= REM_ZERO;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   // FSM next state: redirect aborts; otherwise count down the hold cycles.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      if (hz.redirect) begin
         state_d = ST_RUN;
         rem_d   = REM_ZERO;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (mcs_s) begin
                  // The first hold cycle is spent in RUN, so N-2 remain.
                  rem_d = hz.ex_mc_lat - LAT_W'(2);
                  if (hz.ex_mc_lat >= LAT_W'(3)) begin
                     state_d = ST_MC_BUSY;
                  end else begin
                     state_d = ST_RUN;
                  end
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_MC_BUSY: begin
               rem_d = rem_q - LAT_W'(1);
               // <= rather than == so a corrupted zero count cannot wrap.
               if (rem_q <= LAT_W'(1)) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_MC_BUSY;
               end
            end
            default: begin
               state_d = ST_RUN;
               rem_d   = REM_ZERO;
            end
         endcase
      end
   end

   // Steering outputs by priority: reset, redirect, hold, load-use, normal.
   always_comb begin
      pc_write_s      = 1'b1;
      if_id_load_s    = 1'b1;
      if_id_flush_s   = 1'b0;
      id_ex_load_s    = 1'b1;
      id_ex_bubble_s  = 1'b0;
      ex_mem_bubble_s = 1'b0;
      forward_a_s     = 2'b00;
      forward_b_s     = 2'b00;
      if (!rst) begin
         pc_write_s      = 1'b0;
         if_id_load_s    = 1'b0;
         if_id_flush_s   = 1'b1;
         id_ex_load_s    = 1'b0;
         id_ex_bubble_s  = 1'b1;
         ex_mem_bubble_s = 1'b1;
      end else begin
         forward_a_s = fwd_sel(hz.ex_rs1, hz.mem_rd, hz.mem_regwrite,
                               hz.wb_rd, hz.wb_regwrite);
         forward_b_s = fwd_sel(hz.ex_rs2, hz.mem_rd, hz.mem_regwrite,
                               hz.wb_rd, hz.wb_regwrite);
         if (hz.redirect) begin
            if_id_flush_s   = (FLUSH_DEPTH >= 1);
            id_ex_bubble_s  = (FLUSH_DEPTH >= 2);
            ex_mem_bubble_s = (FLUSH_DEPTH >= 3);
         end else if (hold_s) begin
            // Freeze IF..EX and send bubbles into MEM while EX is occupied.
            pc_write_s      = 1'b0;
            if_id_load_s    = 1'b0;
            id_ex_load_s    = 1'b0;
            ex_mem_bubble_s = 1'b1;
         end else if (lu_s) begin
            pc_write_s     = 1'b0;
            if_id_load_s   = 1'b0;
            id_ex_bubble_s = 1'b1;
         end else begin
            pc_write_s = 1'b1;
         end
      end
   end

   // Event counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= CNT_ZERO;
         flush_cnt_q <= CNT_ZERO;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Saturating counter updates; clear wins over increment.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (hz.clr_counters) begin
         stall_cnt_d = CNT_ZERO;
         flush_cnt_d = CNT_ZERO;
      end else begin
         if (!pc_write_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end else begin
            stall_cnt_d = stall_cnt_q;
         end
         if (hz.redirect && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end else begin
            flush_cnt_d = flush_cnt_q;
         end
      end
   end

   assign hz.pc_write      = pc_write_s;
   assign hz.if_id_load    = if_id_load_s;
   assign hz.if_id_flush   = if_id_flush_s;
   assign hz.id_ex_load    = id_ex_load_s;
   assign hz.id_ex_bubble  = id_ex_bubble_s;
   assign hz.ex_mem_bubble = ex_mem_bubble_s;
   assign hz.forward_a     = forward_a_s;
   assign hz.forward_b     = forward_b_s;
   assign hz.mc_busy       = (state_q == ST_MC_BUSY);
   assign hz.stall_cnt     = stall_cnt_q;
   assign hz.flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl with two instances:
//   dut0 : CNT_W=4, FLUSH_DEPTH=3
//   dut1 : FLUSH_DEPTH=1
// Control outputs are packed as {pc_write, if_id_load, if_id_flush,
// id_ex_load, id_ex_bubble, ex_mem_bubble}.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

   localparam logic [5:0] CTRL_NORM  = 6'b110100;
   localparam logic [5:0] CTRL_LU    = 6'b000110;
   localparam logic [5:0] CTRL_REDIR = 6'b111111;
   localparam logic [5:0] CTRL_HOLD  = 6'b000001;
   localparam logic [5:0] CTRL_RST   = 6'b001011;
   localparam logic [5:0] CTRL_RED1  = 6'b111100;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   pipeline_hazard_ctrl_if #(.REG_AW(5), .LAT_W(4), .CNT_W(4))  hz0 ();
   pipeline_hazard_ctrl_if #(.REG_AW(5), .LAT_W(4), .CNT_W(16)) hz1 ();

   pipeline_hazard_ctrl #(.REG_AW(5), .LAT_W(4), .CNT_W(4), .FLUSH_DEPTH(3)) dut0 (
      .clk (clk),
      .rst (rst),
      .hz  (hz0)
   );

   pipeline_hazard_ctrl #(.REG_AW(5), .LAT_W(4), .CNT_W(16), .FLUSH_DEPTH(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .hz  (hz1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] id_rs1;
      logic [4:0] id_rs2;
      logic       use1;
      logic       use2;
      logic [4:0] ex_rs1;
      logic [4:0] ex_rs2;
      logic [4:0] ex_rd;
      logic       memread;
      logic [4:0] mem_rd;
      logic       mem_wr;
      logic [4:0] wb_rd;
      logic       wb_wr;
      logic       redirect;
      logic [5:0] exp_ctrl;
      logic [1:0] exp_fa;
      logic [1:0] exp_fb;
   } vec_t;

   vec_t vecs[12];

   function automatic logic [5:0] ctrl0();
      return {hz0.pc_write, hz0.if_id_load, hz0.if_id_flush,
              hz0.id_ex_load, hz0.id_ex_bubble, hz0.ex_mem_bubble};
   endfunction

   function automatic logic [5:0] ctrl1();
      return {hz1.pc_write, hz1.if_id_load, hz1.if_id_flush,
              hz1.id_ex_load, hz1.id_ex_bubble, hz1.ex_mem_bubble};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   task automatic idle0();
      hz0.id_rs1 = 5'd0;       hz0.id_rs2 = 5'd0;
      hz0.id_use_rs1 = 1'b0;   hz0.id_use_rs2 = 1'b0;
      hz0.ex_rs1 = 5'd0;       hz0.ex_rs2 = 5'd0;
      hz0.ex_rd = 5'd0;        hz0.ex_memread = 1'b0;
      hz0.ex_mc_start = 1'b0;  hz0.ex_mc_lat = 4'd0;
      hz0.mem_rd = 5'd0;       hz0.mem_regwrite = 1'b0;
      hz0.wb_rd = 5'd0;        hz0.wb_regwrite = 1'b0;
      hz0.redirect = 1'b0;     hz0.clr_counters = 1'b0;
   endtask

   task automatic idle1();
      hz1.id_rs1 = 5'd0;       hz1.id_rs2 = 5'd0;
      hz1.id_use_rs1 = 1'b0;   hz1.id_use_rs2 = 1'b0;
      hz1.ex_rs1 = 5'd0;       hz1.ex_rs2 = 5'd0;
      hz1.ex_rd = 5'd0;        hz1.ex_memread = 1'b0;
      hz1.ex_mc_start = 1'b0;  hz1.ex_mc_lat = 4'd0;
      hz1.mem_rd = 5'd0;       hz1.mem_regwrite = 1'b0;
      hz1.wb_rd = 5'd0;        hz1.wb_regwrite = 1'b0;
      hz1.redirect = 1'b0;     hz1.clr_counters = 1'b0;
   endtask

   task automatic set_lu();
      hz0.ex_memread = 1'b1;
      hz0.ex_rd      = 5'd6;
      hz0.id_rs1     = 5'd6;
      hz0.id_use_rs1 = 1'b1;
   endtask

   task automatic clear_counters();
      @(negedge clk);
      idle0();
      hz0.clr_counters = 1'b1;
      @(negedge clk);
      hz0.clr_counters = 1'b0;
   endtask

   // Single multi-cycle op of latency n, start pulsed for one cycle.
   task automatic run_mc(input int n);
      int holds;
      int ncyc;
      logic exp_busy;
      holds = (n >= 2) ? n - 1 : 0;
      ncyc  = ((n >= 2) ? n : 2) + 1;
      clear_counters();
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         hz0.ex_mc_start = (c == 0);
         hz0.ex_mc_lat   = 4'(n);
         #1;
         exp_busy = (c >= 1) && (c <= n - 2);
         check($sformatf("mc%0d_ctrl_c%0d", n, c), 32'(ctrl0()),
               32'((c < holds) ? CTRL_HOLD : CTRL_NORM));
         check($sformatf("mc%0d_busy_c%0d", n, c), 32'(hz0.mc_busy), 32'(exp_busy));
      end
      @(negedge clk);
      idle0();
      #1;
      check($sformatf("mc%0d_stall_cnt", n), 32'(hz0.stall_cnt), 32'(holds));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      //               id_rs1 id_rs2 u1    u2    ex_rs1 ex_rs2 ex_rd memrd mem_rd mwr   wb_rd  wwr   redir  ctrl        fa     fb
      vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, CTRL_NORM,  2'b00, 2'b00};
      vecs[1]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, CTRL_LU,    2'b00, 2'b00};
      vecs[2]  = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, CTRL_NORM,  2'b00, 2'b00};
      vecs[3]  = '{5'd5, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, CTRL_LU,    2'b00, 2'b00};
      vecs[4]  = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, CTRL_NORM,  2'b00, 2'b00};
      vecs[5]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, CTRL_NORM,  2'b00, 2'b00};
      vecs[6]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, CTRL_NORM,  2'b10, 2'b00};
      vecs[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd0, 5'd0, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, CTRL_NORM,  2'b01, 2'b00};
      vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, CTRL_NORM,  2'b00, 2'b00};
      vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 5'd3, 5'd0, 1'b0, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0, CTRL_NORM,  2'b10, 2'b01};
      vecs[10] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, CTRL_REDIR, 2'b00, 2'b00};
      vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, CTRL_REDIR, 2'b00, 2'b01};

      // Reset: outputs forced regardless of inputs that would forward/redirect.
      rst = 1'b0;
      idle0();
      idle1();
      hz0.ex_rs1 = 5'd7; hz0.mem_rd = 5'd7; hz0.mem_regwrite = 1'b1;
      hz0.redirect = 1'b1;
      @(negedge clk);
      #1;
      check("rst_ctrl",      32'(ctrl0()),       32'(CTRL_RST));
      check("rst_fwd_a",     32'(hz0.forward_a), 32'd0);
      check("rst_mc_busy",   32'(hz0.mc_busy),   32'd0);
      check("rst_stall_cnt", 32'(hz0.stall_cnt), 32'd0);
      check("rst_flush_cnt", 32'(hz0.flush_cnt), 32'd0);
      @(negedge clk);
      idle0();
      rst = 1'b1;

      // Table of single-cycle combinational cases.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         idle0();
         hz0.id_rs1 = vecs[i].id_rs1;     hz0.id_rs2 = vecs[i].id_rs2;
         hz0.id_use_rs1 = vecs[i].use1;   hz0.id_use_rs2 = vecs[i].use2;
         hz0.ex_rs1 = vecs[i].ex_rs1;     hz0.ex_rs2 = vecs[i].ex_rs2;
         hz0.ex_rd = vecs[i].ex_rd;       hz0.ex_memread = vecs[i].memread;
         hz0.mem_rd = vecs[i].mem_rd;     hz0.mem_regwrite = vecs[i].mem_wr;
         hz0.wb_rd = vecs[i].wb_rd;       hz0.wb_regwrite = vecs[i].wb_wr;
         hz0.redirect = vecs[i].redirect;
         #1;
         check($sformatf("vec%0d_ctrl", i), 32'(ctrl0()),       32'(vecs[i].exp_ctrl));
         check($sformatf("vec%0d_fwd_a", i), 32'(hz0.forward_a), 32'(vecs[i].exp_fa));
         check($sformatf("vec%0d_fwd_b", i), 32'(hz0.forward_b), 32'(vecs[i].exp_fb));
      end
      @(negedge clk);
      idle0();
      #1;
      check("tbl_stall_cnt", 32'(hz0.stall_cnt), 32'd2);
      check("tbl_flush_cnt", 32'(hz0.flush_cnt), 32'd2);

      // Multi-cycle occupancy for several latencies, including the edges.
      run_mc(4);
      run_mc(2);
      run_mc(1);
      run_mc(0);
      run_mc(3);
      run_mc(15);

      // Redirect on the third hold cycle of N=8 with a load-use pending.
      clear_counters();
      @(negedge clk);
      hz0.ex_mc_start = 1'b1; hz0.ex_mc_lat = 4'd8;
      #1;
      check("rmc_c0_ctrl", 32'(ctrl0()), 32'(CTRL_HOLD));
      @(negedge clk);
      hz0.ex_mc_start = 1'b0;
      set_lu();
      #1;
      check("rmc_c1_ctrl", 32'(ctrl0()),     32'(CTRL_HOLD));
      check("rmc_c1_busy", 32'(hz0.mc_busy), 32'd1);
      @(negedge clk);
      hz0.redirect = 1'b1;
      #1;
      check("rmc_c2_ctrl", 32'(ctrl0()),     32'(CTRL_REDIR));
      check("rmc_c2_busy", 32'(hz0.mc_busy), 32'd1);
      @(negedge clk);
      hz0.redirect = 1'b0;
      #1;
      check("rmc_c3_ctrl", 32'(ctrl0()),     32'(CTRL_LU));
      check("rmc_c3_busy", 32'(hz0.mc_busy), 32'd0);
      @(negedge clk);
      idle0();
      #1;
      check("rmc_c4_ctrl",  32'(ctrl0()),       32'(CTRL_NORM));
      check("rmc_stall",    32'(hz0.stall_cnt), 32'd3);
      check("rmc_flush",    32'(hz0.flush_cnt), 32'd1);

      // Redirect together with a multi-cycle start: no hold, no MC_BUSY.
      @(negedge clk);
      hz0.ex_mc_start = 1'b1; hz0.ex_mc_lat = 4'd5; hz0.redirect = 1'b1;
      #1;
      check("rsim_c0_ctrl", 32'(ctrl0()), 32'(CTRL_REDIR));
      @(negedge clk);
      idle0();
      #1;
      check("rsim_c1_ctrl", 32'(ctrl0()),     32'(CTRL_NORM));
      check("rsim_c1_busy", 32'(hz0.mc_busy), 32'd0);

      // FLUSH_DEPTH=1 instance: only IF/ID is flushed.
      @(negedge clk);
      hz1.redirect = 1'b1;
      #1;
      check("fd1_redir_ctrl", 32'(ctrl1()), 32'(CTRL_RED1));
      @(negedge clk);
      hz1.redirect = 1'b0;
      #1;
      check("fd1_idle_ctrl", 32'(ctrl1()),       32'(CTRL_NORM));
      check("fd1_flush_cnt", 32'(hz1.flush_cnt), 32'd1);

      // Stall counter saturation, then clear racing an increment.
      clear_counters();
      @(negedge clk);
      set_lu();
      repeat (20) @(negedge clk);
      #1;
      check("sat_stall_cnt", 32'(hz0.stall_cnt), 32'd15);
      @(negedge clk);
      hz0.clr_counters = 1'b1;
      @(negedge clk);
      hz0.clr_counters = 1'b0;
      #1;
      check("clr_stall_cnt", 32'(hz0.stall_cnt), 32'd0);
      @(negedge clk);
      #1;
      check("post_clr_stall", 32'(hz0.stall_cnt), 32'd1);
      idle0();

      // Reset asserted mid-MC_BUSY takes effect immediately.
      @(negedge clk);
      hz0.ex_mc_start = 1'b1; hz0.ex_mc_lat = 4'd8;
      @(negedge clk);
      hz0.ex_mc_start = 1'b0;
      hz0.ex_rs1 = 5'd7; hz0.mem_rd = 5'd7; hz0.mem_regwrite = 1'b1;
      #1;
      check("rmid_busy_before", 32'(hz0.mc_busy), 32'd1);
      rst = 1'b0;
      #1;
      check("rmid_ctrl",  32'(ctrl0()),       32'(CTRL_RST));
      check("rmid_busy",  32'(hz0.mc_busy),   32'd0);
      check("rmid_fwd_a", 32'(hz0.forward_a), 32'd0);
      check("rmid_stall", 32'(hz0.stall_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      idle0();
      @(negedge clk);
      #1;
      check("rmid_after_ctrl", 32'(ctrl0()),     32'(CTRL_NORM));
      check("rmid_after_busy", 32'(hz0.mc_busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
